// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Calculator control sequencer. Conditions the execute and
//                clear buttons (synchronise, debounce, single-pulse), latches
//                the opcode for the ALU, waits a fixed ALU settling time and
//                issues one-cycle accumulator update / reset pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 20,
    parameter int ALU_LAT   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnd,
    input  logic       btnu,
    input  logic [3:0] op_sel,
    input  logic       alu_ovf,
    output logic [3:0] alu_op,
    output logic       acc_reset,
    output logic       acc_update,
    output logic       busy,
    output logic       ovf_sticky,
    output logic [7:0] op_count
);

    localparam int              c_LAT_W   = $clog2(ALU_LAT + 1);
    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [c_LAT_W-1:0] c_LAT  = c_LAT_W'(ALU_LAT);
    localparam logic [c_LAT_W-1:0] c_ONE  = c_LAT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Bit 0 is the execute button, bit 1 the clear button.
    logic [1:0] w_raw;
    logic [1:0] w_pulse;
    logic       w_exec;
    logic       w_clr;

    assign w_raw = {btnu, btnd};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            r_sync1;
            logic            r_sync2;
            logic            r_deb;
            logic            r_deb_prev;
            logic [DB_W-1:0] r_cnt;

            // Synchronise, then accept a level change only after DB_CYCLES
            // consecutive disagreeing samples; any agreeing sample restarts.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_deb      <= 1'b0;
                    r_deb_prev <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_raw[gi];
                    r_sync2    <= r_sync1;
                    r_deb_prev <= r_deb;
                    if (r_sync2 != r_deb) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_deb <= ~r_deb;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            // Rising edge of the debounced level only; releases give nothing.
            assign w_pulse[gi] = r_deb & ~r_deb_prev;
        end
    endgenerate

    assign w_exec = w_pulse[0];
    assign w_clr  = w_pulse[1];

    state_t             r_state;
    logic [c_LAT_W-1:0] r_wait_cnt;
    logic               r_clr;

    // Sequencer: a registered clear pulse occupies one cycle as acc_reset,
    // and at its closing edge wipes the counters and aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_clr      <= 1'b0;
            alu_op     <= 4'd0;
            ovf_sticky <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            r_clr <= w_clr;
            if (r_clr) begin
                r_state    <= S_IDLE;
                r_wait_cnt <= '0;
                ovf_sticky <= 1'b0;
                op_count   <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A clear in the same cycle wins; the execute is dropped.
                        if (w_exec && !w_clr) begin
                            alu_op     <= op_sel;
                            r_wait_cnt <= c_LAT;
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                        if (r_wait_cnt == c_ONE) begin
                            r_state <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        ovf_sticky <= ovf_sticky | alu_ovf;
                        op_count   <= op_count + 8'd1;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Pulses decoded from registered state only; clear masks the update.
    assign acc_reset  = r_clr;
    assign acc_update = (r_state == S_WRITE) && !r_clr;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
